// File: rtl/ofm_writeback.sv
// Output-feature-map write-back: buffers non-throttled result beats and writes them out
// over a valid/ready port at sequential addresses. Define OFM_WB_BYTE_ADDR_EN for byte addressing.
module ofm_writeback #(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 20
) (
  input  logic              clk_100M,
  input  logic              rst_n,
  input  logic              layer_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_total,
  input  logic              data_in_vld,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_vld,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              layer_done,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
`ifdef OFM_WB_BYTE_ADDR_EN
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);
`else
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_next;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, total_q, total_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_vld_q, wr_vld_d;
  logic              busy_q, busy_d, layer_done_q, layer_done_d;
  logic              fifo_full_q, fifo_full_d, overflow_q, overflow_d;
  logic              push, pop, full;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    total_d      = total_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_vld_d     = wr_vld_q;
    busy_d       = busy_q;
    layer_done_d = 1'b0;
    pop          = wr_vld_q & wr_ready;
    full         = (occ_q == OCC_W'(FIFO_DEPTH));
    push         = (state_q == S_RUN) && data_in_vld && (in_cnt_q < total_q) && (!full || pop);
    rd_next      = rd_ptr_q + PTR_W'(1);
    // Any beat that is not pushed is lost, whatever the reason.
    overflow_d   = overflow_q | (data_in_vld & ~push);

    case (state_q)
      S_IDLE: begin
        if (layer_start) begin
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          occ_d      = '0;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          overflow_d = 1'b0;
          total_d    = word_total;
          wr_addr_d  = base_addr;
          wr_vld_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = (word_total == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        // The head register only loads entries already in storage before this edge.
        if (pop) begin
          rd_ptr_d  = rd_next;
          out_cnt_d = out_cnt_q + CNT_W'(1);
          wr_addr_d = wr_addr_q + STRIDE;
          if (occ_q > OCC_W'(1)) begin
            wr_vld_d  = 1'b1;
            wr_data_d = mem_q[rd_next];
          end else begin
            wr_vld_d = 1'b0;
          end
          if (out_cnt_q + CNT_W'(1) == total_q) state_d = S_DONE;
        end else if (!wr_vld_q && occ_q != '0) begin
          wr_vld_d  = 1'b1;
          wr_data_d = mem_q[rd_ptr_q];
        end
        occ_d = occ_q + {{(OCC_W-1){1'b0}}, push} - {{(OCC_W-1){1'b0}}, pop};
      end
      S_DONE: begin
        if (!layer_done_q) begin
          layer_done_d = 1'b1;
          busy_d       = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    fifo_full_d = (occ_d == OCC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_100M) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      total_q      <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_vld_q     <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      fifo_full_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      total_q      <= total_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_vld_q     <= wr_vld_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      fifo_full_q  <= fifo_full_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_vld     = wr_vld_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign layer_done = layer_done_q;
  assign fifo_full  = fifo_full_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Bench for ofm_writeback: randomized beats and handshakes checked against a
// transaction-level model of acceptance, ordering, addressing and layer completion.
module tb_ofm_writeback;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 20;
`ifdef OFM_WB_BYTE_ADDR_EN
  localparam int STRIDE = 64;
`else
  localparam int STRIDE = 1;
`endif

  logic              clk_100M = 1'b0;
  logic              rst_n = 1'b0;
  logic              layer_start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_total = '0;
  logic              data_in_vld = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              wr_vld, wr_ready = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy, layer_done, fifo_full, overflow;

  ofm_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_100M(clk_100M), .rst_n(rst_n), .layer_start(layer_start), .base_addr(base_addr),
    .word_total(word_total), .data_in_vld(data_in_vld), .data_in(data_in), .wr_vld(wr_vld),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .layer_done(layer_done), .fifo_full(fifo_full), .overflow(overflow));

  initial forever #5 clk_100M = ~clk_100M;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk_100M) cyc++;

  // Reference model: spec-level bookkeeping of accepted/written beats, sampled mid-cycle.
  int m_phase = 0, m_dcnt = 0, m_acc = 0, m_wr = 0, m_total = 0, m_occ = 0;
  bit m_ovf = 0;
  int done_cnt = 0, done_cyc = 0, pop_cyc = 0;
  int ff_bad = 0, ovf_bad = 0, stall_bad = 0;
  logic [DATA_W-1:0] got_d[$];
  logic [ADDR_W-1:0] got_a[$];
  bit prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;

  always @(negedge clk_100M) begin
    bit p_pop, p_push;
    if (!rst_n) begin
      m_phase = 0; m_occ = 0; m_ovf = 0; m_acc = 0; m_wr = 0; prev_stall = 0;
    end else begin
      if (fifo_full !== (m_occ == DEPTH)) ff_bad++;
      if (overflow !== m_ovf) ovf_bad++;
      if (prev_stall && (wr_vld !== 1'b1 || wr_data !== prev_data || wr_addr !== prev_addr))
        stall_bad++;
      prev_stall = wr_vld && !wr_ready;
      prev_data  = wr_data;
      prev_addr  = wr_addr;
      if (layer_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (m_phase == 2) begin
        m_dcnt++;
        if (m_dcnt == 3) m_phase = 0;
      end
      p_pop  = (wr_vld === 1'b1) && (wr_ready === 1'b1);
      p_push = (m_phase == 1) && data_in_vld && (m_acc < m_total) && (m_occ < DEPTH || p_pop);
      if (data_in_vld && !p_push) m_ovf = 1;
      if (p_push) m_acc++;
      if (p_pop) begin
        got_d.push_back(wr_data);
        got_a.push_back(wr_addr);
        pop_cyc = cyc;
        m_wr++;
        if (m_phase == 1 && m_wr == m_total) begin m_phase = 2; m_dcnt = 0; end
      end
      m_occ = m_occ + int'(p_push) - int'(p_pop);
      if (layer_start && m_phase == 0) begin
        m_total = int'(word_total); m_acc = 0; m_wr = 0; m_occ = 0; m_ovf = 0;
        if (m_total == 0) begin m_phase = 2; m_dcnt = 0; end
        else m_phase = 1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_100M);
    #1;
  endtask

  task automatic start_layer(input logic [ADDR_W-1:0] b, input int t);
    got_d.delete();
    got_a.delete();
    base_addr   = b;
    word_total  = CNT_W'(t);
    layer_start = 1'b1;
    step();
    layer_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt != d0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (wr_vld !== 1'b0)   begin errors++; $display("FAIL rst_wr_vld got %b exp 0", wr_vld); end
    checks++; if (wr_addr !== '0)    begin errors++; $display("FAIL rst_wr_addr got %0h exp 0", wr_addr); end
    checks++; if (wr_data !== '0)    begin errors++; $display("FAIL rst_wr_data got %0h exp 0", wr_data); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (layer_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", layer_done); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", fifo_full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] b[4];
    logic [ADDR_W-1:0] ea;
    int d0 = done_cnt;
    bit ok;
    for (int i = 0; i < 4; i++) b[i] = rand_beat();
    wr_ready = 1'b1;
    start_layer(32'h1000, 4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b exp 1", busy); end
    data_in_vld = 1'b1; data_in = b[0];
    step();
    checks++; if (wr_vld !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %b exp 0", wr_vld); end
    data_in = b[1];
    step();
    checks++;
    if (wr_vld !== 1'b1 || wr_data !== b[0] || wr_addr !== 32'h1000) begin
      errors++; $display("FAIL basic_latency_head got vld %b addr %0h exp vld 1 addr 1000", wr_vld, wr_addr);
    end
    data_in = b[2]; step();
    data_in = b[3]; step();
    data_in_vld = 1'b0;
    wait_done(d0, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 exp 1"); end
    checks++; if (got_d.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      ea = 32'h1000 + ADDR_W'(i * STRIDE);
      checks++;
      if (got_d[i] !== b[i] || got_a[i] !== ea) begin
        errors++; $display("FAIL basic_write%0d got addr %0h exp addr %0h", i, got_a[i], ea);
      end
    end
    checks++; if (done_cyc != pop_cyc + 2) begin errors++; $display("FAIL basic_done_timing got %0d exp %0d", done_cyc, pop_cyc + 2); end
    checks++; if (layer_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done %b busy %b exp 0 0", layer_done, busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", overflow); end
    repeat (2) step();
  endtask

  task automatic test_zero_total();
    start_layer($urandom, 0);
    checks++; if (busy !== 1'b1 || layer_done !== 1'b0) begin errors++; $display("FAIL zero_c1 got busy %b done %b exp 1 0", busy, layer_done); end
    step();
    checks++; if (busy !== 1'b0 || layer_done !== 1'b1) begin errors++; $display("FAIL zero_c2 got busy %b done %b exp 0 1", busy, layer_done); end
    step();
    checks++; if (layer_done !== 1'b0) begin errors++; $display("FAIL zero_c3 got %b exp 0", layer_done); end
    checks++; if (got_d.size() != 0 || wr_vld !== 1'b0) begin errors++; $display("FAIL zero_writes got %0d exp 0", got_d.size()); end
    repeat (2) step();
  endtask

  task automatic test_extra_beat();
    logic [DATA_W-1:0] b[5];
    int d0 = done_cnt;
    bit ok;
    for (int i = 0; i < 5; i++) b[i] = rand_beat();
    wr_ready = 1'b1;
    start_layer($urandom, 4);
    for (int i = 0; i < 5; i++) begin data_in_vld = 1'b1; data_in = b[i]; step(); end
    data_in_vld = 1'b0;
    wait_done(d0, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL extra_done_timeout got 0 exp 1"); end
    checks++; if (got_d.size() != 4) begin errors++; $display("FAIL extra_count got %0d exp 4", got_d.size()); end
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      checks++; if (got_d[i] !== b[i]) begin errors++; $display("FAIL extra_data%0d got %0h exp %0h", i, got_d[i], b[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL extra_ovf got %b exp 1", overflow); end
    repeat (2) step();
  endtask

  task automatic test_idle_beat();
    int d0;
    bit ok;
    start_layer($urandom, 0);
    repeat (3) step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_ovf_clear got %b exp 0", overflow); end
    data_in_vld = 1'b1; data_in = rand_beat();
    step();
    data_in_vld = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL idle_beat_ovf got %b exp 1", overflow); end
    d0 = done_cnt;
    wr_ready = 1'b1;
    start_layer(32'h40, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_start_clears got %b exp 0", overflow); end
    data_in_vld = 1'b1; data_in = rand_beat();
    step();
    data_in_vld = 1'b0;
    wait_done(d0, 20, ok);
    checks++; if (!ok || got_a.size() != 1) begin errors++; $display("FAIL idle_single_layer got %0d exp 1", got_a.size()); end
    repeat (2) step();
  endtask

  task automatic test_stall();
    logic [DATA_W-1:0] sent[$];
    logic [ADDR_W-1:0] b = $urandom;
    logic [ADDR_W-1:0] ea;
    int t = $urandom_range(6, 12);
    int d0 = done_cnt;
    int sb0 = stall_bad;
    bit ok = 0;
    start_layer(b, t);
    for (int i = 0; i < 300; i++) begin
      wr_ready = i[0];
      if (m_acc < t && $urandom_range(0, 9) < 7) begin
        data_in_vld = 1'b1; data_in = rand_beat(); sent.push_back(data_in);
      end else data_in_vld = 1'b0;
      step();
      if (done_cnt != d0) begin ok = 1; break; end
    end
    data_in_vld = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got 0 exp 1"); end
    checks++; if (got_d.size() != t) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_d.size(), t); end
    for (int i = 0; i < got_d.size() && i < sent.size(); i++) begin
      ea = b + ADDR_W'(i * STRIDE);
      checks++;
      if (got_d[i] !== sent[i] || got_a[i] !== ea) begin
        errors++; $display("FAIL stall_write%0d got addr %0h exp addr %0h", i, got_a[i], ea);
      end
    end
    checks++; if (stall_bad != sb0) begin errors++; $display("FAIL stall_hold got %0d exp %0d", stall_bad, sb0); end
    wr_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] sent[$];
    logic [ADDR_W-1:0] b, ea;
    int t, vp, rp, d0;
    bit ok;
    for (int l = 0; l < 4; l++) begin
      sent.delete();
      b  = (l == 0) ? 32'hFFFF_FFFE : $urandom;
      t  = $urandom_range(1, 24);
      vp = $urandom_range(30, 100);
      rp = $urandom_range(30, 100);
      d0 = done_cnt;
      ok = 0;
      start_layer(b, t);
      for (int i = 0; i < 1000; i++) begin
        wr_ready = ($urandom_range(0, 99) < rp);
        if (m_acc < t && m_occ < DEPTH - 2 && $urandom_range(0, 99) < vp) begin
          data_in_vld = 1'b1; data_in = rand_beat(); sent.push_back(data_in);
        end else data_in_vld = 1'b0;
        step();
        if (done_cnt != d0) begin ok = 1; break; end
      end
      data_in_vld = 1'b0;
      checks++; if (!ok || got_d.size() != t) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", l, got_d.size(), t); end
      for (int i = 0; i < got_d.size() && i < sent.size(); i++) begin
        ea = b + ADDR_W'(i * STRIDE);
        checks++;
        if (got_d[i] !== sent[i] || got_a[i] !== ea) begin
          errors++; $display("FAIL rand%0d_write%0d got addr %0h exp addr %0h", l, i, got_a[i], ea);
        end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand%0d_ovf got %b exp 0", l, overflow); end
      repeat (3) step();
    end
  endtask

  task automatic test_full_pop();
    logic [DATA_W-1:0] sent[$];
    int d0 = done_cnt;
    bit ok;
    wr_ready = 1'b0;
    start_layer($urandom, 20);
    for (int i = 0; i < 16; i++) begin
      data_in_vld = 1'b1; data_in = rand_beat(); sent.push_back(data_in);
      step();
      if (i == 14) begin
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL fullpop_15 got %b exp 0", fifo_full); end
      end
    end
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_16 got full %b ovf %b exp 1 0", fifo_full, overflow); end
    wr_ready = 1'b1;
    data_in = rand_beat(); sent.push_back(data_in);
    step();
    checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_same got full %b ovf %b exp 1 0", fifo_full, overflow); end
    for (int i = 0; i < 3; i++) begin data_in = rand_beat(); sent.push_back(data_in); step(); end
    data_in_vld = 1'b0;
    wait_done(d0, 60, ok);
    checks++; if (!ok || got_d.size() != 20) begin errors++; $display("FAIL fullpop_count got %0d exp 20", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 20; i++) begin
      checks++; if (got_d[i] !== sent[i]) begin errors++; $display("FAIL fullpop_data%0d got %0h exp %0h", i, got_d[i], sent[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", overflow); end
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] sent[$];
    int d0 = done_cnt;
    wr_ready = 1'b0;
    start_layer($urandom, 20);
    for (int i = 0; i < 20; i++) begin
      data_in_vld = 1'b1; data_in = rand_beat(); sent.push_back(data_in);
      step();
      if (i == 15) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full got %b exp 1", fifo_full); end
      end
    end
    data_in_vld = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b exp 1", overflow); end
    wr_ready = 1'b1;
    repeat (40) step();
    checks++; if (got_d.size() != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      checks++; if (got_d[i] !== sent[i]) begin errors++; $display("FAIL bp_data%0d got %0h exp %0h", i, got_d[i], sent[i]); end
    end
    checks++; if (done_cnt != d0 || busy !== 1'b1) begin errors++; $display("FAIL bp_stuck got done %0d busy %b exp %0d 1", done_cnt, busy, d0); end
    rst_n = 1'b0; step(); rst_n = 1'b1; repeat (2) step();
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] sent[$];
    int d0;
    bit ok;
    wr_ready = 1'b0;
    start_layer($urandom, 8);
    for (int i = 0; i < 2; i++) begin data_in_vld = 1'b1; data_in = rand_beat(); step(); end
    data_in_vld = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_vld !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || busy !== 1'b0 ||
        layer_done !== 1'b0 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got vld %b busy %b full %b ovf %b exp all 0", wr_vld, busy, fifo_full, overflow);
    end
    @(negedge clk_100M);
    step();
    rst_n = 1'b1;
    step();
    d0 = done_cnt;
    wr_ready = 1'b1;
    start_layer(32'h200, 3);
    for (int i = 0; i < 3; i++) begin data_in_vld = 1'b1; data_in = rand_beat(); sent.push_back(data_in); step(); end
    data_in_vld = 1'b0;
    wait_done(d0, 30, ok);
    checks++; if (!ok || got_d.size() != 3) begin errors++; $display("FAIL midrst_relayer got %0d exp 3", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 3; i++) begin
      checks++; if (got_d[i] !== sent[i] || got_a[i] !== 32'h200 + ADDR_W'(i * STRIDE)) begin errors++; $display("FAIL midrst_write%0d got addr %0h", i, got_a[i]); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", overflow); end
    repeat (3) step();
  endtask

  task automatic test_model_agreement();
    checks++; if (ff_bad != 0)  begin errors++; $display("FAIL model_fifo_full got %0d exp 0", ff_bad); end
    checks++; if (ovf_bad != 0) begin errors++; $display("FAIL model_overflow got %0d exp 0", ovf_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_total();
    test_extra_beat();
    test_idle_beat();
    test_stall();
    test_random();
    test_full_pop();
    test_backpressure();
    test_reset_mid();
    test_model_agreement();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
